// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RV32I
// funct3 encodings, AXI response codes and access-size helpers.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    DONE
  } lsu_state_e;

  typedef enum logic [1:0] {
    SIZE_BYTE,
    SIZE_HALF,
    SIZE_WORD
  } lsu_size_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  // Access size from the low funct3 bits; undefined encodings fall back to word.
  function automatic lsu_size_e access_size(input logic [2:0] f3);
    case ({1'b0, f3[1:0]})
      F3_LB:   return SIZE_BYTE;
      F3_LH:   return SIZE_HALF;
      F3_LW:   return SIZE_WORD;
      default: return SIZE_WORD;
    endcase
  endfunction

  // True when the byte lane is not a multiple of the access size.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lane);
    case (access_size(f3))
      SIZE_HALF: return lane[0];
      SIZE_WORD: return lane != 2'b00;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data alignment for the LSU: picks and extends the load lane
// from the returned bus word, and builds the shifted store word and strobes.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] bus_rdata,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [3:0]  base_strb;

  assign lane_byte = bus_rdata[{lane, 3'b000} +: 8];
  assign lane_half = lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];

  // Select the addressed byte/halfword and sign- or zero-extend it.
  always_comb begin
    load_data = bus_rdata;
    case (funct3)
      F3_LB:   load_data = {{24{lane_byte[7]}}, lane_byte};
      F3_LBU:  load_data = {24'b0, lane_byte};
      F3_LH:   load_data = {{16{lane_half[15]}}, lane_half};
      F3_LHU:  load_data = {16'b0, lane_half};
      default: load_data = bus_rdata;
    endcase
  end

  // Unshifted strobe pattern for the access size; the lane shift truncates to 4 bits.
  always_comb begin
    base_strb = 4'b1111;
    case ({1'b0, funct3[1:0]})
      F3_SB:   base_strb = 4'b0001;
      F3_SH:   base_strb = 4'b0011;
      F3_SW:   base_strb = 4'b1111;
      default: base_strb = 4'b1111;
    endcase
  end

  assign bus_wstrb = base_strb << lane;
  assign bus_wdata = store_data << {lane, 3'b000};

endmodule

// File: rtl/lsu.sv
// Load/store unit: one AXI4-Lite transaction per memory instruction, then a
// single lsu_finish pulse back to fetch. Non-memory instructions retire via
// DONE without touching the bus.
// Optional build macro: LSU_MISALIGN_CHECK_EN turns misaligned halfword/word
// accesses into immediate errors that never reach the bus.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_valid,
  input  logic              mem_ren,
  input  logic              mem_wen,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              lsu_finish,
  output logic              lsu_err,
  output logic              io_master_arvalid,
  output logic [ADDR_W-1:0] io_master_araddr,
  input  logic              io_master_arready,
  output logic              io_master_rready,
  input  logic              io_master_rvalid,
  input  logic [1:0]        io_master_rresp,
  input  logic [DATA_W-1:0] io_master_rdata,
  output logic              io_master_awvalid,
  output logic [ADDR_W-1:0] io_master_awaddr,
  input  logic              io_master_awready,
  output logic              io_master_wvalid,
  output logic [DATA_W-1:0] io_master_wdata,
  output logic [3:0]        io_master_wstrb,
  input  logic              io_master_wready,
  output logic              io_master_bready,
  input  logic              io_master_bvalid,
  input  logic [1:0]        io_master_bresp
);

  lsu_state_e        state_q, state_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic              finish_q, finish_d;
  logic              err_q, err_d;
  logic              err_pend_q, err_pend_d;

  logic [DATA_W-1:0] load_data;

  lsu_align u_align (
    .funct3    (funct3_q),
    .lane      (addr_q[1:0]),
    .bus_rdata (io_master_rdata),
    .store_data(wdata_q),
    .load_data (load_data),
    .bus_wdata (io_master_wdata),
    .bus_wstrb (io_master_wstrb)
  );

  // Next-state and next-output logic; every bus-facing control is registered.
  always_comb begin
    state_d    = state_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    bready_d   = bready_q;
    err_pend_d = err_pend_q;
    finish_d   = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (inst_valid) begin
          funct3_d   = funct3;
          addr_d     = addr;
          wdata_d    = wdata;
          err_pend_d = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
          if ((mem_ren || mem_wen) && is_misaligned(funct3, addr[1:0])) begin
            err_pend_d = 1'b1;
            state_d    = DONE;
          end else
`endif
          if (mem_ren) begin
            arvalid_d = 1'b1;
            rready_d  = 1'b1;
            state_d   = RD_ADDR;
          end else if (mem_wen) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_REQ;
          end else begin
            state_d = DONE;
          end
        end
      end
      RD_ADDR, RD_DATA: begin
        if (io_master_arready) begin
          arvalid_d = 1'b0;
          state_d   = RD_DATA;
        end
        if (io_master_rvalid) begin
          rdata_d    = load_data;
          err_pend_d = io_master_rresp != AXI_RESP_OKAY;
          arvalid_d  = 1'b0;
          rready_d   = 1'b0;
          state_d    = DONE;
        end
      end
      WR_REQ: begin
        if (io_master_awready) awvalid_d = 1'b0;
        if (io_master_wready)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (io_master_bvalid) begin
          err_pend_d = io_master_bresp != AXI_RESP_OKAY;
          bready_d   = 1'b0;
          state_d    = DONE;
        end
      end
      DONE: begin
        finish_d = 1'b1;
        err_d    = err_pend_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any outstanding bus response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      funct3_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      finish_q   <= 1'b0;
      err_q      <= 1'b0;
      err_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
      finish_q   <= finish_d;
      err_q      <= err_d;
      err_pend_q <= err_pend_d;
    end
  end

  assign rdata             = rdata_q;
  assign lsu_finish        = finish_q;
  assign lsu_err           = err_q;
  assign io_master_arvalid = arvalid_q;
  assign io_master_araddr  = addr_q;
  assign io_master_rready  = rready_q;
  assign io_master_awvalid = awvalid_q;
  assign io_master_awaddr  = addr_q;
  assign io_master_wvalid  = wvalid_q;
  assign io_master_bready  = bready_q;

endmodule
